div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the EX stage beside the ALU. It produces the `ex_stall` signal that the hazard unit uses to freeze every pipeline register while a division is in flight. It delivers a single registered result with a one-cycle `done` strobe when the stall releases.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (power of two, ≥ 8)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  valid divide op present in ID/EX (held while stalled)
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `dividend`  in  XLEN  rs1 value (forwarded)
- `divisor`  in  XLEN  rs2 value (forwarded)
- `flush`  in  1  abort current op (trap/redirect)
- `ex_stall`  out  1  pipeline freeze request to hazard unit
- `done`  out  1  result valid this cycle
- `result`  out  XLEN  quotient or remainder per `op`

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `start`=1 and `flush`=0: latch `op`, operand signs, and |dividend|, |divisor| (unsigned ops take raw values).
  - Assert `ex_stall` combinationally in that same cycle.
  - Load iteration counter with XLEN-1 and go to BUSY.
- BUSY: one restoring shift-subtract step per cycle on an XLEN+1-bit partial remainder. `ex_stall`=1. Counter reaching 0 → DONE.
- DONE:
  - `ex_stall`=0 and `done`=1. `result` holds the sign-corrected value.
  - Pipeline advances at the end of this cycle.
  - Always → IDLE.
- Sign correction: quotient negated if dividend and divisor signs differ (signed ops); remainder takes the dividend's sign.
- Special cases (architectural, RISC-V spec):
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend, remainder 0.
- `result` is registered and holds its value until the next DONE. `done` is high only in DONE.
- `flush`=1 in any state: next state IDLE and `ex_stall`=0 in that cycle. No `done`, `result` unchanged.
- `start` in DONE is the same instruction and is ignored. A new `start` is honoured only from IDLE.
- `rst`: state IDLE, counter 0, `done`=0, `result`=0. `ex_stall` is forced to 0 while `rst` is high, which aborts any operation in progress.

## Timing
- Cycle 0: `start` sampled in IDLE, `ex_stall`=1.
- Cycles 1..XLEN: BUSY, `ex_stall`=1.
- Cycle XLEN+1: DONE, `done`=1.
- Total stall is XLEN+1 cycles (33 at XLEN=32), and the result is visible on cycle XLEN+1.
- Back-to-back divides: the second `start` is seen in IDLE the cycle after DONE, giving no gap beyond IDLE.
- `ex_stall` is combinational from `start`, state, `flush`, and `rst`. All other outputs are registered.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - Divisor 0, signed overflow, and |dividend| < |divisor| bypass BUSY and go IDLE → DONE.
  - This gives a 1-cycle stall, with `done` on cycle 1. For the |dividend| < |divisor| case, the quotient is 0 and the remainder is the dividend.
- Undefined: every op runs the full XLEN iterations. Results are bit-identical in both builds; only latency differs.

## Test plan
- DIV 100 / 7: `ex_stall` high for cycles 0–32, `done` at cycle 33, `result`=14. REM of the same operands → 2.
- REM -7 / 2 → 0xFFFFFFFF (-1). DIV -7 / 2 → 0xFFFFFFFD (-3). DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- DIV 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5. Stall is 1 cycle with `DIV_EARLY_OUT_EN`, 33 without.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, with no X or exception.
- `flush` at BUSY cycle 10: `ex_stall` drops that cycle, state is IDLE next, no `done`, `result` keeps its prior value. Repeat with `rst` at BUSY cycle 10: all outputs return to 0.
- Two consecutive DIVU (20/3 then 9/4): results 6 then 2, with `done` pulses exactly 34 cycles apart.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Requests a pipeline freeze (ex_stall) while a divide is in flight and
// presents a registered result with a one-cycle done strobe.
// Optional build macro: DIV_EARLY_OUT_EN (divide-by-zero, signed overflow
// and |dividend| < |divisor| skip the iteration loop).
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            ex_stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div_zero;
  logic [XLEN-1:0] r_quot;     // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] r_rem;      // partial remainder, always < divisor
  logic [XLEN-1:0] r_dvsr;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // op[0] selects unsigned, op[1] selects remainder
  logic            w_signed;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_early;

  logic [XLEN:0]   w_rem_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_step;
  logic [XLEN-1:0] w_quot_step;
  logic [XLEN-1:0] w_busy_result;
  logic [XLEN-1:0] w_early_result;

  // Applies sign correction and the architectural divide-by-zero quotient.
  function automatic logic [XLEN-1:0] f_result(
    input logic            is_rem,
    input logic            neg_q,
    input logic            neg_r,
    input logic            div_zero,
    input logic [XLEN-1:0] q_mag,
    input logic [XLEN-1:0] r_mag
  );
    logic [XLEN-1:0] v;
    if (is_rem)
      v = neg_r ? ({XLEN{1'b0}} - r_mag) : r_mag;
    else if (div_zero)
      v = {XLEN{1'b1}};
    else
      v = neg_q ? ({XLEN{1'b0}} - q_mag) : q_mag;
    return v;
  endfunction

  assign w_signed   = ~op[0];
  assign w_sign_a   = w_signed & dividend[XLEN-1];
  assign w_sign_b   = w_signed & divisor[XLEN-1];
  assign w_abs_a    = w_sign_a ? ({XLEN{1'b0}} - dividend) : dividend;
  assign w_abs_b    = w_sign_b ? ({XLEN{1'b0}} - divisor) : divisor;
  assign w_div_zero = (divisor == {XLEN{1'b0}});
  assign w_ovf      = w_signed & (dividend == SMIN) & (divisor == {XLEN{1'b1}});

`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_div_zero | w_ovf | (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: shift in next dividend bit, subtract if it fits.
  // The subtraction only matters when it fits, so XLEN bits suffice.
  assign w_rem_shift = {r_rem, r_quot[XLEN-1]};
  assign w_qbit      = (w_rem_shift >= {1'b0, r_dvsr});
  assign w_diff      = w_rem_shift[XLEN-1:0] - r_dvsr;
  assign w_rem_step  = w_qbit ? w_diff : w_rem_shift[XLEN-1:0];
  assign w_quot_step = {r_quot[XLEN-2:0], w_qbit};

  assign w_busy_result  = f_result(r_is_rem, r_neg_q, r_neg_r, r_div_zero,
                                   w_quot_step, w_rem_step);
  // Shortcut cases: overflow gives quotient SMIN / remainder 0, the others
  // give quotient 0 (or all-ones for /0) and remainder = dividend.
  assign w_early_result = f_result(op[1], w_sign_a ^ w_sign_b, w_sign_a, w_div_zero,
                                   w_ovf ? SMIN : {XLEN{1'b0}},
                                   w_ovf ? {XLEN{1'b0}} : w_abs_a);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic and the combinational stall request
  always_comb begin
    w_state_next = r_state;
    ex_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          ex_stall     = 1'b1;
          w_state_next = w_early ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        ex_stall = 1'b1;
        if (r_cnt == {CW{1'b0}}) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) begin
      w_state_next = S_IDLE;
      ex_stall     = 1'b0;
    end
    if (rst) ex_stall = 1'b0;
  end

  // Operand capture, iteration datapath and registered result/done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_quot     <= {XLEN{1'b0}};
      r_rem      <= {XLEN{1'b0}};
      r_dvsr     <= {XLEN{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_done     <= 1'b0;
      r_result   <= {XLEN{1'b0}};
    end else begin
      r_done <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_is_rem   <= op[1];
            r_neg_q    <= w_sign_a ^ w_sign_b;
            r_neg_r    <= w_sign_a;
            r_div_zero <= w_div_zero;
            r_quot     <= w_abs_a;
            r_rem      <= {XLEN{1'b0}};
            r_dvsr     <= w_abs_b;
            r_cnt      <= CW'(XLEN - 1);
            if (w_early) r_result <= w_early_result;
          end
        end
        S_BUSY: begin
          if (!flush) begin
            r_quot <= w_quot_step;
            r_rem  <= w_rem_step;
            if (r_cnt == {CW{1'b0}}) r_result <= w_busy_result;
            else                     r_cnt    <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven checks of div_unit plus hand-written flush,
// reset-abort and back-to-back sequences.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        ex_stall;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .ex_stall (ex_stall),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one op starting next cycle and returns in its done cycle
  // (start stays asserted, as the pipeline holds it until it advances).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int stall,
                        output logic done_seen, output logic done_early, output int dcyc);
    @(posedge clk); #1;
    start = 1'b1; op = o; dividend = a; divisor = b;
    #1;
    stall = 0;
    done_early = 1'b0;
    while (ex_stall && stall < 100) begin
      stall++;
      if (done) done_early = 1'b1;
      @(posedge clk); #2;
    end
    done_seen = done;
    res = result;
    dcyc = cyc;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] last_res;
    int          stall;
    int          exp_stall;
    logic        dseen;
    logic        dearly;
    int          dcyc;
    int          dcyc10;
    int          dcyc11;
    bit          seen_done;

    vecs[0]  = '{2'b00, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{2'b10, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[3]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[4]  = '{2'b01, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  1'b0};
    vecs[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[9]  = '{2'b01, 32'd20,         32'd3,          32'd6,          1'b0};
    vecs[10] = '{2'b01, 32'd9,          32'd4,          32'd2,          1'b0};
    vecs[11] = '{2'b10, 32'd3,          32'd10,         32'd3,          1'b1};
    vecs[12] = '{2'b00, 32'hFFFF_FFFD,  32'd10,         32'd0,          1'b1};
    vecs[13] = '{2'b00, 32'hFFFF_FFEC,  32'hFFFF_FFFD,  32'd6,          1'b0};
    vecs[14] = '{2'b10, 32'hFFFF_FFEC,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  1'b0};
    vecs[15] = '{2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[16] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
    vecs[17] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};

    // Reset: outputs clear, stall forced low even with start asserted
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1; #1;
    chk("stall_in_reset", {31'd0, ex_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_stall", {31'd0, ex_stall}, 32'd0);

    dcyc10 = 0;
    dcyc11 = 0;
    last_res = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, stall, dseen, dearly, dcyc);
      exp_stall = (vecs[i].early && EARLY) ? 1 : 33;
      $display("vec %0d op=%0d a=0x%08h b=0x%08h result=0x%08h stall=%0d", i,
               vecs[i].op, vecs[i].a, vecs[i].b, res, stall);
      chk($sformatf("v%0d_stall", i), stall, exp_stall);
      chk($sformatf("v%0d_done", i), {31'd0, dseen}, 32'd1);
      chk($sformatf("v%0d_done_during_stall", i), {31'd0, dearly}, 32'd0);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      if (i == 9)  dcyc10 = dcyc;
      if (i == 10) dcyc11 = dcyc;
      last_res = vecs[i].exp;
    end
    chk("b2b_done_spacing", dcyc11 - dcyc10, 32'd34);

    // Result holds after DONE
    @(posedge clk); #1; start = 1'b0; #1;
    chk("idle_done_low", {31'd0, done}, 32'd0);
    chk("idle_result_hold", result, last_res);

    // Flush at BUSY cycle 10
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; dividend = 32'd100; divisor = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; #1;
    chk("flush_stall", {31'd0, ex_stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; #1;
    chk("flush_idle_stall", {31'd0, ex_stall}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      if (done) seen_done = 1'b1;
      @(posedge clk); #2;
    end
    chk("flush_no_done", {31'd0, seen_done}, 32'd0);
    chk("flush_result_hold", result, last_res);
    $display("flush sequence result=0x%08h", result);
    // Next op must start cleanly from IDLE
    run_op(2'b11, 32'd17, 32'd5, res, stall, dseen, dearly, dcyc);
    $display("post-flush REMU 17/5 result=0x%08h stall=%0d", res, stall);
    chk("postflush_stall", stall, 33);
    chk("postflush_result", res, 32'd2);

    // Reset at BUSY cycle 10
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("rst_busy_stall", {31'd0, ex_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; #1;
    chk("rst_busy_done", {31'd0, done}, 32'd0);
    chk("rst_busy_result", result, 32'd0);
    chk("rst_busy_idle_stall", {31'd0, ex_stall}, 32'd0);
    $display("reset-abort sequence result=0x%08h", result);
    run_op(2'b01, 32'd1000, 32'd3, res, stall, dseen, dearly, dcyc);
    $display("post-reset DIVU 1000/3 result=0x%08h stall=%0d", res, stall);
    chk("postrst_result", res, 32'd333);
    @(posedge clk); #1; start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
